// File: rtl/blur_window_ctrl.sv
// ---------------------------------------------------------------------------
// blur_window_ctrl
//
// Purpose:
//   Streams a raster-order frame through two line buffers and a 3x3 shift
//   window. The registered window taps feed an external combinational blur
//   kernel, whose result is registered back in as the filtered pixel together
//   with the centre coordinate of that window. Border centres (first/last
//   row and column) produce no output, so one frame yields
//   (IMG_W-2)*(IMG_H-2) output pixels.
//
// Ports:
//   clk            single clock, all state on its rising edge
//   rst_n          asynchronous active-low reset
//   frame_start    one-cycle pulse, starts (or restarts) a frame
//   in_valid       in_pixel carries a pixel this cycle (no back-pressure)
//   in_pixel       input pixel, PIX_W bits
//   win_p0..win_p8 registered 3x3 window (p0..p2 top row, p6..p8 bottom)
//   win_valid      window taps form a valid interior window
//   kern_result    kernel output computed from the current window taps
//   bypass         (only with BLUR_BYPASS_EN) output the window centre tap
//   out_valid      out_pixel / out_x / out_y are valid
//   out_pixel      filtered pixel
//   out_x, out_y   centre coordinate of out_pixel
//   busy           high while the FSM is in FILL or RUN
//   frame_done     one-cycle pulse with the last output of a frame
//
// Configuration:
//   BLUR_BYPASS_EN  when defined, adds the bypass input; while bypass is
//                   high out_pixel is the registered centre tap (win_p4)
//                   instead of kern_result, with unchanged timing.
// ---------------------------------------------------------------------------
module blur_window_ctrl #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       in_valid,
  input  logic [PIX_W-1:0]           in_pixel,
  output logic [PIX_W-1:0]           win_p0,
  output logic [PIX_W-1:0]           win_p1,
  output logic [PIX_W-1:0]           win_p2,
  output logic [PIX_W-1:0]           win_p3,
  output logic [PIX_W-1:0]           win_p4,
  output logic [PIX_W-1:0]           win_p5,
  output logic [PIX_W-1:0]           win_p6,
  output logic [PIX_W-1:0]           win_p7,
  output logic [PIX_W-1:0]           win_p8,
  output logic                       win_valid,
  input  logic [PIX_W-1:0]           kern_result,
`ifdef BLUR_BYPASS_EN
  input  logic                       bypass,
`endif
  output logic                       out_valid,
  output logic [PIX_W-1:0]           out_pixel,
  output logic [$clog2(IMG_W)-1:0]   out_x,
  output logic [$clog2(IMG_H)-1:0]   out_y,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Control state
  state_t                       state_q, state_d;
  logic [XW-1:0]                x_q, x_d;
  logic [YW-1:0]                y_q, y_d;
  logic                         busy_q, busy_d;

  // Window taps: index 0 is the oldest (left) column, index 2 the newest
  logic [2:0][PIX_W-1:0]        top_q, top_d;
  logic [2:0][PIX_W-1:0]        mid_q, mid_d;
  logic [2:0][PIX_W-1:0]        bot_q, bot_d;
  logic                         win_valid_q, win_valid_d;
  logic                         win_last_q, win_last_d;
  logic [XW-1:0]                win_cx_q, win_cx_d;
  logic [YW-1:0]                win_cy_q, win_cy_d;

  // Output stage
  logic                         out_valid_q, out_valid_d;
  logic [PIX_W-1:0]             out_pixel_q, out_pixel_d;
  logic [XW-1:0]                out_x_q, out_x_d;
  logic [YW-1:0]                out_y_q, out_y_d;
  logic                         frame_done_q, frame_done_d;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2
  logic [PIX_W-1:0]             lb1_mem [IMG_W];
  logic [PIX_W-1:0]             lb2_mem [IMG_W];
  logic [PIX_W-1:0]             lb1_rd;
  logic [PIX_W-1:0]             lb2_rd;

  // Per-cycle decode
  logic                         in_frame;
  logic                         abort;
  logic                         accept;
  logic [XW-1:0]                cur_x;
  logic [YW-1:0]                cur_y;
  logic                         col_last;
  logic                         row_last;

  // Accept/abort decode and the coordinate of the pixel on the bus. A pixel
  // arriving together with frame_start is pixel (0,0) of the new frame, so
  // the live coordinate is forced to zero in that cycle.
  always_comb begin
    in_frame = (state_q == FILL) || (state_q == RUN);
    abort    = frame_start && in_frame;
    accept   = in_valid && (frame_start || in_frame);
    cur_x    = frame_start ? '0 : x_q;
    cur_y    = frame_start ? '0 : y_q;
    col_last = (cur_x == XW'(IMG_W - 1));
    row_last = (cur_y == YW'(IMG_H - 1));
    lb1_rd   = lb1_mem[cur_x];
    lb2_rd   = lb2_mem[cur_x];
  end

  // Raster counters and FSM next state. Counters only move on accepted
  // pixels, so in_valid gaps simply hold everything.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    state_d = state_q;

    if (frame_start) begin
      x_d = '0;
      y_d = '0;
    end
    if (accept) begin
      if (col_last) begin
        x_d = '0;
        y_d = row_last ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start) state_d = FILL;
      end
      FILL: begin
        if (frame_start) begin
          state_d = FILL;
        end else if (accept && (cur_x == '0) && (cur_y == YW'(2))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_start) begin
          state_d = FILL;
        end else if (accept && col_last && row_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The final window is in flight here; it leaves on this edge.
        if (frame_start) begin
          state_d = FILL;
        end else if (win_valid_q && win_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FILL) || (state_d == RUN);
  end

  // Window shift. Each accepted pixel pushes one column: line-buffer row
  // y-2 on top, row y-1 in the middle, the live pixel at the bottom. The
  // window is only flagged valid from x>=2, by which point all three columns
  // were shifted in on the current line, so no column ever straddles lines.
  always_comb begin
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    win_cx_d    = win_cx_q;
    win_cy_d    = win_cy_q;

    if (accept) begin
      top_d       = {lb2_rd,   top_q[2], top_q[1]};
      mid_d       = {lb1_rd,   mid_q[2], mid_q[1]};
      bot_d       = {in_pixel, bot_q[2], bot_q[1]};
      win_valid_d = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      win_last_d  = col_last && row_last;
      win_cx_d    = cur_x - XW'(1);
      win_cy_d    = cur_y - YW'(1);
    end
  end

  // Output stage: capture the kernel result one cycle after the window is
  // presented. An abort kills the window that is currently in flight, which
  // also suppresses frame_done for the abandoned frame.
  always_comb begin
    out_valid_d  = win_valid_q && !abort;
    frame_done_d = win_valid_q && win_last_q && !abort;
    out_pixel_d  = out_pixel_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;

    if (win_valid_q) begin
`ifdef BLUR_BYPASS_EN
      out_pixel_d = bypass ? mid_q[1] : kern_result;
`else
      out_pixel_d = kern_result;
`endif
      out_x_d     = win_cx_q;
      out_y_d     = win_cy_q;
    end
  end

  // All control, window and output registers. Reset drops straight back to
  // IDLE, abandoning any frame; a new frame_start is needed to resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      win_cx_q     <= '0;
      win_cy_q     <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      win_cx_q     <= win_cx_d;
      win_cy_q     <= win_cy_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are plain storage with no reset: rows 0 and 1 of every
  // frame rewrite them before any valid window can read them. The old
  // contents are read combinationally above before this write lands.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[cur_x] <= in_pixel;
      lb2_mem[cur_x] <= lb1_rd;
    end
  end

  assign win_p0     = top_q[0];
  assign win_p1     = top_q[1];
  assign win_p2     = top_q[2];
  assign win_p3     = mid_q[0];
  assign win_p4     = mid_q[1];
  assign win_p5     = mid_q[2];
  assign win_p6     = bot_q[0];
  assign win_p7     = bot_q[1];
  assign win_p8     = bot_q[2];
  assign win_valid  = win_valid_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_blur_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_blur_window_ctrl
//
// Directed bench for blur_window_ctrl on a small 8x6 frame, which gives
// (8-2)*(6-2) = 24 outputs per frame, last centre at (6,4). The ramp pattern
// is x + 256*y (plus a per-frame offset). The attached kernel is a 1-2-1
// Gaussian; on a linear ramp it returns exactly the centre value.
// ---------------------------------------------------------------------------
module tb_blur_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 17;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int N  = (W - 2) * (H - 2);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_start;
  logic            in_valid;
  logic [PW-1:0]   in_pixel;
  logic [PW-1:0]   wp [9];
  logic            win_valid;
  logic [PW-1:0]   kern_result;
  logic            out_valid;
  logic [PW-1:0]   out_pixel;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic            busy;
  logic            frame_done;
  logic            kern_junk;
  logic [PW+3:0]   ksum;
`ifdef BLUR_BYPASS_EN
  logic            bypass;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // External blur kernel; kern_junk forces a garbage result so the bypass
  // path can be told apart from the kernel path.
  always_comb begin
    ksum = {4'b0, wp[0]} + ({4'b0, wp[1]} << 1) + {4'b0, wp[2]}
         + ({4'b0, wp[3]} << 1) + ({4'b0, wp[4]} << 2) + ({4'b0, wp[5]} << 1)
         + {4'b0, wp[6]} + ({4'b0, wp[7]} << 1) + {4'b0, wp[8]};
    kern_result = kern_junk ? '1 : ksum[PW+3:4];
  end

  blur_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .win_p0      (wp[0]),
    .win_p1      (wp[1]),
    .win_p2      (wp[2]),
    .win_p3      (wp[3]),
    .win_p4      (wp[4]),
    .win_p5      (wp[5]),
    .win_p6      (wp[6]),
    .win_p7      (wp[7]),
    .win_p8      (wp[8]),
    .win_valid   (win_valid),
    .kern_result (kern_result),
`ifdef BLUR_BYPASS_EN
    .bypass      (bypass),
`endif
    .out_valid   (out_valid),
    .out_pixel   (out_pixel),
    .out_x       (out_x),
    .out_y       (out_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Ramp pixel value for coordinate (x,y)
  function automatic logic [PW-1:0] ramp(input int x, input int y, input int off);
    return PW'(x + 256 * y + off);
  endfunction

  // Present one input beat, let the DUT take it, then settle 1 ns past the edge
  task automatic drive_cycle(input logic fs, input logic v, input logic [PW-1:0] pix);
    frame_start = fs;
    in_valid    = v;
    in_pixel    = pix;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
  endtask

  // Everything must read zero while reset is held
  task automatic test_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_pixel    = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({win_valid, out_valid, busy, frame_done} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got %b exp 0000", {win_valid, out_valid, busy, frame_done});
    end
    n_checks++;
    if (out_pixel !== '0 || out_x !== '0 || out_y !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out got pix=%0d x=%0d y=%0d exp 0", out_pixel, out_x, out_y);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (wp[k] !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_tap%0d got %0d exp 0", k, wp[k]);
      end
    end
    rst_n = 1'b1;
    drive_cycle(1'b0, 1'b1, PW'(55));
    n_checks++;
    if (busy !== 1'b0 || win_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_ignore got busy=%b win_valid=%b exp 0 0", busy, win_valid);
    end
  endtask

  // Constant 100 frame: 24 outputs of 100, frame_done on the last at (6,4)
  task automatic test_constant();
    int outs = 0;
    int dones = 0;
    for (int c = 0; c < W * H + 4; c++) begin
      if (c < W * H) drive_cycle(c == 0, 1'b1, PW'(100));
      else           drive_cycle(1'b0, 1'b0, '0);
      if (out_valid) begin
        outs++;
        n_checks++;
        if (out_pixel !== PW'(100)) begin
          n_fail++;
          $display("[TB] FAIL const_pix got %0d exp 100", out_pixel);
        end
      end
      if (frame_done) begin
        dones++;
        n_checks++;
        if (outs != N || out_x !== XW'(W - 2) || out_y !== YW'(H - 2)) begin
          n_fail++;
          $display("[TB] FAIL const_done got outs=%0d x=%0d y=%0d exp %0d %0d %0d",
                   outs, out_x, out_y, N, W - 2, H - 2);
        end
      end
    end
    n_checks++;
    if (outs != N || dones != 1) begin
      n_fail++;
      $display("[TB] FAIL const_count got outs=%0d dones=%0d exp %0d 1", outs, dones, N);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL const_idle got busy=%b exp 0", busy);
    end
  endtask

  // Ramp frame: every window tap, every output, and the 2-cycle latency
  task automatic test_ramp();
    int oidx = 0;
    int widx = 0;
    int dones = 0;
    int cx, cy;
    for (int c = 0; c < W * H + 4; c++) begin
      if (c < W * H) drive_cycle(c == 0, 1'b1, ramp(c % W, c / W, 0));
      else           drive_cycle(1'b0, 1'b0, '0);
      if (c == 0) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL ramp_busy got %b exp 1", busy);
        end
      end
      // pixel (2,2) was presented in this call: window now, output next call
      if (c == 2 * W + 2) begin
        n_checks++;
        if (win_valid !== 1'b1 || out_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL ramp_lat_win got win=%b out=%b exp 1 0", win_valid, out_valid);
        end
      end
      if (c == 2 * W + 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== XW'(1) || out_y !== YW'(1)) begin
          n_fail++;
          $display("[TB] FAIL ramp_lat_out got v=%b x=%0d y=%0d exp 1 1 1", out_valid, out_x, out_y);
        end
      end
      if (win_valid) begin
        cx = 1 + widx % (W - 2);
        cy = 1 + widx / (W - 2);
        for (int k = 0; k < 9; k++) begin
          n_checks++;
          if (wp[k] !== ramp(cx - 1 + k % 3, cy - 1 + k / 3, 0)) begin
            n_fail++;
            $display("[TB] FAIL ramp_tap%0d at (%0d,%0d) got %0d exp %0d",
                     k, cx, cy, wp[k], ramp(cx - 1 + k % 3, cy - 1 + k / 3, 0));
          end
        end
        widx++;
      end
      if (out_valid) begin
        cx = 1 + oidx % (W - 2);
        cy = 1 + oidx / (W - 2);
        n_checks++;
        if (out_x !== XW'(cx) || out_y !== YW'(cy) || out_pixel !== ramp(cx, cy, 0)) begin
          n_fail++;
          $display("[TB] FAIL ramp_out got (%0d,%0d)=%0d exp (%0d,%0d)=%0d",
                   out_x, out_y, out_pixel, cx, cy, ramp(cx, cy, 0));
        end
        n_checks++;
        if (frame_done !== (oidx == N - 1)) begin
          n_fail++;
          $display("[TB] FAIL ramp_done_pos got %b at out %0d", frame_done, oidx);
        end
        oidx++;
      end
      if (frame_done) dones++;
    end
    n_checks++;
    if (oidx != N || widx != N || dones != 1) begin
      n_fail++;
      $display("[TB] FAIL ramp_count got outs=%0d wins=%0d dones=%0d exp %0d %0d 1",
               oidx, widx, dones, N, N);
    end
  endtask

  // Ramp with in_valid dropped every third cycle; junk on the bus meanwhile
  task automatic test_gaps();
    int p = 0;
    int oidx = 0;
    int dones = 0;
    int cx, cy;
    for (int c = 0; c < 80; c++) begin
      if (p < W * H && c % 3 != 2) begin
        drive_cycle(p == 0, 1'b1, ramp(p % W, p / W, 0));
        p++;
      end else begin
        drive_cycle(1'b0, 1'b0, PW'(17'h1ABCD));
        if (p < W * H) begin
          n_checks++;
          if (win_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gap_win got %b exp 0 at cycle %0d", win_valid, c);
          end
        end
      end
      if (out_valid) begin
        cx = 1 + oidx % (W - 2);
        cy = 1 + oidx / (W - 2);
        n_checks++;
        if (out_x !== XW'(cx) || out_y !== YW'(cy) || out_pixel !== ramp(cx, cy, 0)) begin
          n_fail++;
          $display("[TB] FAIL gap_out got (%0d,%0d)=%0d exp (%0d,%0d)=%0d",
                   out_x, out_y, out_pixel, cx, cy, ramp(cx, cy, 0));
        end
        oidx++;
      end
      if (frame_done) dones++;
    end
    n_checks++;
    if (oidx != N || dones != 1) begin
      n_fail++;
      $display("[TB] FAIL gap_count got outs=%0d dones=%0d exp %0d 1", oidx, dones, N);
    end
  endtask

  // Abort at pixel (3,3) by a new frame (offset 3000) presented as its (0,0)
  task automatic test_abort();
    int oidx = 0;
    int off = 0;
    int dones = 0;
    int cx, cy;
    int ab = 3 * W + 3;
    for (int c = 0; c < ab + W * H + 4; c++) begin
      if (c < ab) begin
        drive_cycle(c == 0, 1'b1, ramp(c % W, c / W, 0));
      end else if (c - ab < W * H) begin
        drive_cycle(c == ab, 1'b1, ramp((c - ab) % W, (c - ab) / W, 3000));
      end else begin
        drive_cycle(1'b0, 1'b0, '0);
      end
      if (c == ab) begin
        oidx = 0;
        off  = 3000;
        n_checks++;
        if (win_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL abort_flush got win=%b out=%b busy=%b exp 0 0 1",
                   win_valid, out_valid, busy);
        end
      end
      if (out_valid) begin
        cx = 1 + oidx % (W - 2);
        cy = 1 + oidx / (W - 2);
        n_checks++;
        if (out_x !== XW'(cx) || out_y !== YW'(cy) || out_pixel !== ramp(cx, cy, off)) begin
          n_fail++;
          $display("[TB] FAIL abort_out got (%0d,%0d)=%0d exp (%0d,%0d)=%0d",
                   out_x, out_y, out_pixel, cx, cy, ramp(cx, cy, off));
        end
        n_checks++;
        if (frame_done !== (off == 3000 && oidx == N - 1)) begin
          n_fail++;
          $display("[TB] FAIL abort_done_pos got %b at out %0d", frame_done, oidx);
        end
        oidx++;
      end
      if (frame_done) dones++;
    end
    n_checks++;
    if (oidx != N || dones != 1) begin
      n_fail++;
      $display("[TB] FAIL abort_count got outs=%0d dones=%0d exp %0d 1", oidx, dones, N);
    end
  endtask

  // Reset with a window in flight, then pixels without frame_start
  task automatic test_reset_midframe();
    int stray = 0;
    for (int c = 0; c < 3 * W; c++) begin
      drive_cycle(c == 0, 1'b1, ramp(c % W, c / W, 0));
    end
    n_checks++;
    if (win_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_pre got win=%b exp 1", win_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (win_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_now got win=%b out=%b busy=%b exp 0 0 0",
               win_valid, out_valid, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < W * H + 4; c++) begin
      drive_cycle(1'b0, 1'b1, ramp(c % W, (c / W) % H, 0));
      if (win_valid || out_valid || busy || frame_done) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("[TB] FAIL midrst_ignore got %0d active cycles exp 0", stray);
    end
  endtask

  // Second frame starts in the cycle right after the first frame's last pixel
  task automatic test_back_to_back();
    int oidx = 0;
    int dones = 0;
    int cx, cy, loc, off;
    for (int c = 0; c < 2 * W * H + 4; c++) begin
      if (c < W * H) begin
        drive_cycle(c == 0, 1'b1, ramp(c % W, c / W, 0));
      end else if (c < 2 * W * H) begin
        drive_cycle(c == W * H, 1'b1, ramp((c - W * H) % W, (c - W * H) / W, 5000));
      end else begin
        drive_cycle(1'b0, 1'b0, '0);
      end
      if (out_valid) begin
        loc = oidx % N;
        off = (oidx >= N) ? 5000 : 0;
        cx  = 1 + loc % (W - 2);
        cy  = 1 + loc / (W - 2);
        n_checks++;
        if (out_x !== XW'(cx) || out_y !== YW'(cy) || out_pixel !== ramp(cx, cy, off)) begin
          n_fail++;
          $display("[TB] FAIL b2b_out got (%0d,%0d)=%0d exp (%0d,%0d)=%0d",
                   out_x, out_y, out_pixel, cx, cy, ramp(cx, cy, off));
        end
        n_checks++;
        if (frame_done !== (loc == N - 1)) begin
          n_fail++;
          $display("[TB] FAIL b2b_done_pos got %b at out %0d", frame_done, oidx);
        end
        oidx++;
      end
      if (frame_done) dones++;
    end
    n_checks++;
    if (oidx != 2 * N || dones != 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_count got outs=%0d dones=%0d exp %0d 2", oidx, dones, 2 * N);
    end
  endtask

`ifdef BLUR_BYPASS_EN
  // Bypass with a garbage kernel: outputs must still be the ramp centre
  task automatic test_bypass();
    int oidx = 0;
    int cx, cy;
    kern_junk = 1'b1;
    bypass    = 1'b1;
    for (int c = 0; c < W * H + 4; c++) begin
      if (c < W * H) drive_cycle(c == 0, 1'b1, ramp(c % W, c / W, 0));
      else           drive_cycle(1'b0, 1'b0, '0);
      if (out_valid) begin
        cx = 1 + oidx % (W - 2);
        cy = 1 + oidx / (W - 2);
        n_checks++;
        if (out_pixel !== ramp(cx, cy, 0)) begin
          n_fail++;
          $display("[TB] FAIL bypass_out at (%0d,%0d) got %0d exp %0d",
                   cx, cy, out_pixel, ramp(cx, cy, 0));
        end
        oidx++;
      end
    end
    n_checks++;
    if (oidx != N) begin
      n_fail++;
      $display("[TB] FAIL bypass_count got %0d exp %0d", oidx, N);
    end
    kern_junk = 1'b0;
    bypass    = 1'b0;
  endtask
`endif

  // Safety net so the run always ends on its own
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence
  initial begin
    kern_junk = 1'b0;
`ifdef BLUR_BYPASS_EN
    bypass = 1'b0;
`endif
    $display("[TB] starting blur_window_ctrl bench");
    test_reset();
    test_constant();
    test_ramp();
    test_gaps();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
`ifdef BLUR_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blur_window_ctrl.md
BLUR_WINDOW_CTRL -- requirements
Module: blur_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 256: pixels per line.
REQ-002 Parameter IMG_H, default 256: lines per frame.
REQ-003 Parameter PIX_W, default 17: pixel width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse marking the start of a frame.
REQ-007 in_valid  input  1  in_pixel carries a raster-order pixel this cycle (no back-pressure).
REQ-008 in_pixel  input  PIX_W  input pixel.
REQ-009 win_p0..win_p8  output  PIX_W each  registered 3x3 window (p0..p2 top row left to right, p3..p5 middle, p6..p8 bottom) to the external combinational blur kernel.
REQ-010 win_valid  output  1  window taps are a valid interior window.
REQ-011 kern_result  input  PIX_W  kernel output computed from the current win_p0..win_p8.
REQ-012 out_valid  output  1  out_pixel, out_x and out_y are valid.
REQ-013 out_pixel  output  PIX_W  filtered pixel.
REQ-014 out_x, out_y  output  clog2(IMG_W), clog2(IMG_H)  center coordinate of out_pixel.
REQ-015 busy  output  1  high in states FILL and RUN.
REQ-016 frame_done  output  1  one-cycle pulse coincident with the frame's last out_valid.

Function
REQ-017 FSM states SHALL be IDLE, FILL, RUN and DONE.
REQ-018 IDLE SHALL go to FILL on frame_start; FILL SHALL go to RUN when the first pixel of row 2 is accepted; RUN SHALL go to DONE when pixel (IMG_W-1, IMG_H-1) is accepted; DONE SHALL go to IDLE after the last output.
REQ-019 in_valid SHALL be ignored in IDLE and DONE, except per REQ-020.
REQ-020 A pixel with in_valid and frame_start high in the same cycle SHALL be accepted as pixel (0,0).
REQ-021 Column counter SHALL wrap from IMG_W-1 to 0 and increment the row counter; counters advance only on accepted pixels.
REQ-022 Two IMG_W-deep line buffers SHALL hold rows y-1 and y-2; each accepted pixel is written at index x after reading the old contents.
REQ-023 A three-column shift register per row SHALL form the window; the newest column enters at p2/p5/p8.
REQ-024 win_valid SHALL rise one cycle after accepting pixel (x,y) with x>=2 and y>=2; window center is (x-1,y-1).
REQ-025 Window contents SHALL never span lines: columns from the previous line are not used when x<2.
REQ-026 out_valid SHALL follow win_valid by one cycle; out_pixel is kern_result registered; total latency from accepted input to output is 2 cycles.
REQ-027 Exactly (IMG_W-2)*(IMG_H-2) outputs SHALL be produced per frame; border centers produce none.
REQ-028 frame_start while busy SHALL abort the frame: counters cleared, the window pipeline flushed (win_valid and out_valid low next cycle), and the FSM re-entered at FILL; no frame_done for the aborted frame.
REQ-029 Gaps in in_valid SHALL stall the window without producing outputs or corrupting state.

Reset
REQ-030 With rst_n low, the FSM SHALL be IDLE, counters 0, and win_p0..win_p8, win_valid, out_valid, out_pixel, out_x, out_y, busy and frame_done all 0.
REQ-031 Line buffer contents need not be reset; they SHALL be unobservable before being rewritten.
REQ-032 Reset asserted mid-frame SHALL abandon the frame immediately; the next frame requires a new frame_start.

Configuration
REQ-033 With macro BLUR_BYPASS_EN defined, an input port bypass (1 bit) SHALL exist; while bypass is high, out_pixel SHALL be the registered win_p4 instead of kern_result, with timing unchanged.
REQ-034 Without BLUR_BYPASS_EN, the bypass port SHALL be absent and out_pixel always SHALL be the registered kern_result.

Verification
REQ-035 Constant frame: all in_pixel=100 with the blur kernel attached -> exactly 64516 outputs, all equal to 100, with frame_done on the last output, where out_x=254 and out_y=254.
REQ-036 Ramp frame: in_pixel=x+256*y -> first window at center (1,1) has p0=0, p4=257, p8=514, and out_valid occurs 2 cycles after accepting pixel (2,2).
REQ-037 Idle gaps: in_valid deasserted every third cycle -> output values and count identical to REQ-035.
REQ-038 Abort: frame_start at pixel (10,100) followed by a full new frame -> no frame_done for the first frame, and exactly 64516 correct outputs for the second.
REQ-039 Reset at pixel (0,50): win_valid=0 and out_valid=0 immediately; subsequent in_valid without frame_start -> no outputs.
REQ-040 Under BLUR_BYPASS_EN, bypass=1 with ramp input -> out_pixel at center (x,y) equals x+256*y.
